// File: rtl/fm_voice_scheduler.sv
`default_nettype none
// ============================================================================
// fm_voice_scheduler : issues one note-gen slot per (operator, channel) per
// frame, operator-major, with algorithm routing flags and delayed writeback.
// Revision: 1.0
// ============================================================================

module fm_voice_scheduler #(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_OPS      = 4,
  parameter int NUM_BITS     = 32,
  parameter int LATENCY      = 3,
  localparam int C_CHAN_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int C_OP_W      = $clog2(NUM_OPS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_req_i,
  input  logic [1:0]                             algo_sel_i,
  input  logic [NUM_CHANNELS*NUM_OPS*NUM_BITS-1:0] tuning_i,
  output logic                                   slot_valid_o,
  output logic [C_CHAN_W-1:0]                    slot_chan_o,
  output logic [C_OP_W-1:0]                      slot_op_o,
  output logic [NUM_BITS-1:0]                    tuning_word_o,
  output logic                                   mod_en_o,
  output logic [C_OP_W-1:0]                      mod_src_o,
  output logic                                   wb_valid_o,
  output logic [C_CHAN_W-1:0]                    wb_chan_o,
  output logic [C_OP_W-1:0]                      wb_op_o,
  output logic                                   wb_sum_en_o,
  output logic                                   frame_done_o,
  output logic                                   busy_o,
  output logic                                   overrun_o
);

  // Idle cycles between operator groups so op o writes back before op o+1 reads it.
  localparam int C_GAP_CYC = (LATENCY + 1 > NUM_CHANNELS) ? (LATENCY + 1 - NUM_CHANNELS) : 0;
  localparam int C_GAP_W   = (C_GAP_CYC > 1) ? $clog2(C_GAP_CYC) : 1;

  localparam logic [C_CHAN_W-1:0] C_LAST_CHAN = C_CHAN_W'(NUM_CHANNELS - 1);
  localparam logic [C_OP_W-1:0]   C_LAST_OP   = C_OP_W'(NUM_OPS - 1);
  localparam logic [C_GAP_W-1:0]  C_LAST_GAP  = C_GAP_W'((C_GAP_CYC > 0) ? (C_GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [C_CHAN_W-1:0] chan_q, chan_d;
  logic [C_OP_W-1:0]   op_q, op_d;
  logic [C_GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]          algo_q, algo_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;

  logic                slot_valid_q, slot_valid_d;
  logic [C_CHAN_W-1:0] slot_chan_q, slot_chan_d;
  logic [C_OP_W-1:0]   slot_op_q, slot_op_d;
  logic [NUM_BITS-1:0] tuning_q, tuning_d;
  logic                mod_en_q, mod_en_d;
  logic [C_OP_W-1:0]   mod_src_q, mod_src_d;
  logic                sum_q, sum_d;
  logic                last_q, last_d;

  logic [LATENCY-1:0]               wb_valid_q;
  logic [LATENCY-1:0]               wb_sum_q;
  logic [LATENCY-1:0]               wb_last_q;
  logic [LATENCY-1:0][C_CHAN_W-1:0] wb_chan_q;
  logic [LATENCY-1:0][C_OP_W-1:0]   wb_op_q;

  logic                frame_done_w;
  logic [NUM_BITS-1:0] tune_words [NUM_OPS][NUM_CHANNELS];

  generate
    for (genvar go = 0; go < NUM_OPS; go++) begin : g_op
      for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_ch
        assign tune_words[go][gc] = tuning_i[(go*NUM_CHANNELS+gc)*NUM_BITS +: NUM_BITS];
      end
    end
  endgenerate

  assign frame_done_w = wb_last_q[LATENCY-1];

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    op_d         = op_q;
    gap_d        = gap_q;
    algo_d       = algo_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    slot_valid_d = 1'b0;
    slot_chan_d  = '0;
    slot_op_d    = '0;
    tuning_d     = '0;
    mod_en_d     = 1'b0;
    mod_src_d    = '0;
    sum_d        = 1'b0;
    last_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_req_i || pending_q) begin
          state_d   = S_ISSUE;
          chan_d    = '0;
          op_d      = '0;
          algo_d    = algo_sel_i;
          pending_d = pending_q && frame_req_i;
        end
      end

      S_ISSUE: begin
        slot_valid_d = 1'b1;
        slot_chan_d  = chan_q;
        slot_op_d    = op_q;
        tuning_d     = tune_words[op_q][chan_q];
        last_d       = (chan_q == C_LAST_CHAN) && (op_q == C_LAST_OP);

        case (algo_q)
          2'd0: begin
            mod_en_d = (op_q != '0);
            sum_d    = (op_q == C_LAST_OP);
          end
          2'd1: begin
            sum_d    = 1'b1;
          end
          2'd2: begin
            mod_en_d = op_q[0];
            sum_d    = op_q[0];
          end
          default: begin
            mod_en_d = (op_q != '0);
            sum_d    = (op_q != '0);
          end
        endcase
        // Fan-out always modulates from op 0; the others take the preceding op.
        mod_src_d = (mod_en_d && (algo_q != 2'd3)) ? (op_q - 1'b1) : '0;

        if (chan_q == C_LAST_CHAN) begin
          if (op_q == C_LAST_OP) begin
            state_d = S_DRAIN;
          end else begin
            chan_d = '0;
            op_d   = op_q + 1'b1;
            if (C_GAP_CYC > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end else begin
          chan_d = chan_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == C_LAST_GAP) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (frame_done_w) begin
          if (pending_q) begin
            state_d = S_ISSUE;
            chan_d  = '0;
            op_d    = '0;
            algo_d  = algo_sel_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A request arriving as the pending one is consumed becomes the new pending.
    if (state_q != S_IDLE) begin
      if ((state_q == S_DRAIN) && frame_done_w && pending_q) begin
        pending_d = frame_req_i;
      end else if (frame_req_i) begin
        if (pending_q) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      chan_q       <= '0;
      op_q         <= '0;
      gap_q        <= '0;
      algo_q       <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_chan_q  <= '0;
      slot_op_q    <= '0;
      tuning_q     <= '0;
      mod_en_q     <= 1'b0;
      mod_src_q    <= '0;
      sum_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      op_q         <= op_d;
      gap_q        <= gap_d;
      algo_q       <= algo_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      slot_valid_q <= slot_valid_d;
      slot_chan_q  <= slot_chan_d;
      slot_op_q    <= slot_op_d;
      tuning_q     <= tuning_d;
      mod_en_q     <= mod_en_d;
      mod_src_q    <= mod_src_d;
      sum_q        <= sum_d;
      last_q       <= last_d;
    end
  end

  // Writeback mirror of the issued slot, LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= '0;
      wb_sum_q   <= '0;
      wb_last_q  <= '0;
      wb_chan_q  <= '0;
      wb_op_q    <= '0;
    end else begin
      wb_valid_q[0] <= slot_valid_q;
      wb_sum_q[0]   <= sum_q;
      wb_last_q[0]  <= last_q;
      wb_chan_q[0]  <= slot_chan_q;
      wb_op_q[0]    <= slot_op_q;
      for (int i = 1; i < LATENCY; i++) begin
        wb_valid_q[i] <= wb_valid_q[i-1];
        wb_sum_q[i]   <= wb_sum_q[i-1];
        wb_last_q[i]  <= wb_last_q[i-1];
        wb_chan_q[i]  <= wb_chan_q[i-1];
        wb_op_q[i]    <= wb_op_q[i-1];
      end
    end
  end

  assign slot_valid_o  = slot_valid_q;
  assign slot_chan_o   = slot_chan_q;
  assign slot_op_o     = slot_op_q;
  assign tuning_word_o = tuning_q;
  assign mod_en_o      = mod_en_q;
  assign mod_src_o     = mod_src_q;
  assign wb_valid_o    = wb_valid_q[LATENCY-1];
  assign wb_chan_o     = wb_chan_q[LATENCY-1];
  assign wb_op_o       = wb_op_q[LATENCY-1];
  assign wb_sum_en_o   = wb_sum_q[LATENCY-1];
  assign frame_done_o  = frame_done_w;
  assign busy_o        = (state_q != S_IDLE);
  assign overrun_o     = overrun_q;

endmodule

`default_nettype wire

// File: doc/fm_voice_scheduler.md
Name: fm_voice_scheduler

Overview:
Time-multiplexed slot scheduler for the next-generation N-operator FM engine. It replaces the fixed carrier/modulator sequencing with NUM_OPS operators per voice across NUM_CHANNELS voices, and supports four selectable operator algorithms. On each frame request from the I2S transmitter it issues one slot per (operator, channel), sends per-slot tuning words and routing flags to the shared note-gen pipeline, and emits matching writeback strobes LATENCY cycles later.

Parameters:
NUM_CHANNELS, 16, voices per frame (>=1)
NUM_OPS, 4, operators per voice (>=2, even)
NUM_BITS, 32, tuning word width
LATENCY, 3, note-gen pipeline depth in cycles, issue to writeback (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_req  in  1  one-cycle pulse: start a frame (I2S ready)
algo_sel  in  2  operator algorithm, sampled at frame start
tuning_in  in  NUM_CHANNELS*NUM_OPS*NUM_BITS  flat tuning words; slot (c,o) at bits [(o*NUM_CHANNELS+c)*NUM_BITS +: NUM_BITS]
slot_valid  out  1  issue strobe
slot_chan  out  $clog2(NUM_CHANNELS) (min 1)  channel of issued slot
slot_op  out  $clog2(NUM_OPS)  operator of issued slot
tuning_word  out  NUM_BITS  tuning word of issued slot
mod_en  out  1  issued op is phase-modulated by the previous op's stored output
mod_src  out  $clog2(NUM_OPS)  operator index supplying modulation
wb_valid  out  1  writeback strobe
wb_chan  out  as slot_chan  writeback channel
wb_op  out  as slot_op  writeback operator
wb_sum_en  out  1  writeback output is summed into the voice mix
frame_done  out  1  one-cycle pulse on the final writeback of a frame
busy  out  1  high from frame start until frame_done
overrun  out  1  sticky: frame_req dropped

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, the pending flag clears, and the writeback pipeline is flushed. Reset mid-frame aborts the frame with no frame_done.
- FSM states are IDLE, ISSUE, GAP and DRAIN.
- IDLE: on frame_req (or pending set), latch algo_sel, go to ISSUE with c=0, o=0, and set busy in the same cycle as the transition.
- ISSUE: one slot per cycle, operator-major order (all channels of op 0, then op 1, ...). Outputs are registered, so slot_* appear the cycle after the counter value. After the last channel of op o:
  - if o<NUM_OPS-1 and GAP_CYC>0, go to GAP;
  - otherwise go to the next op;
  - after the final slot (c=NUM_CHANNELS-1, o=NUM_OPS-1), go to DRAIN.
- GAP: GAP_CYC = max(0, LATENCY+1-NUM_CHANNELS) idle cycles (slot_valid=0), then ISSUE. This guarantees op o's writeback for channel c precedes op o+1's issue for channel c.
- DRAIN: wait for the final writeback. In that cycle frame_done=1 and wb_valid=1. Next cycle: busy=0, then go to IDLE, or straight to ISSUE if pending is set.
- Writeback: wb_valid/wb_chan/wb_op/wb_sum_en equal the slot_valid/slot_chan/slot_op/sum flag from exactly LATENCY cycles earlier (shift register).
- Algorithms (latched per frame):
  - 0 = serial chain: mod_en=(o>0), mod_src=o-1, sum only o=NUM_OPS-1.
  - 1 = parallel: mod_en=0, all ops summed.
  - 2 = pairs: odd o modulated by o-1; odd ops summed.
  - 3 = fan-out: o>0 modulated by op 0; ops 1..NUM_OPS-1 summed.
  - When mod_en=0, mod_src=0.
- frame_req while busy sets pending (one-deep). A further frame_req while pending is already set sets overrun. frame_req in the same cycle pending is consumed counts as the new pending.
- Counter wrap: the channel counter wraps NUM_CHANNELS-1 to 0 with an op increment. Nothing wraps beyond the final op.
- Frame length in cycles from start to frame_done: NUM_OPS*NUM_CHANNELS + (NUM_OPS-1)*GAP_CYC + LATENCY.

Test Plan:
- Defaults, algo 0, one frame_req → 64 slot_valid pulses in order (c0o0..c15o0, c0o1, ...). tuning_word matches the flat bus. wb_sum_en=1 only on the 16 op-3 writebacks. frame_done at cycle 67 after start; busy falls the next cycle.
- NUM_CHANNELS=2, LATENCY=3 → GAP_CYC=2. Check 2 idle cycles between op groups, and check wb of (c,o) always precedes issue of (c,o+1). Total frame length 8+6+3=17.
- algo 2 and algo 3 frames → mod_en/mod_src per op: algo 2 gives op1←0, op3←2. Algo 3 gives ops 1-3 ←0, with sum mask 1110. algo_sel changed mid-frame → no effect until the next frame.
- frame_req mid-frame, then another → the first starts back-to-back after frame_done with no IDLE cycle; the second sets overrun=1, which stays set until rst.
- rst asserted mid-ISSUE → next cycle all outputs 0 and no frame_done. A later frame_req restarts at c0o0.
